// File: rtl/echo_cancel_sequencer.sv
// Per-sample handshake sequencer for the echo-cancellation datapath: converters -> adaptive filter -> canceller -> output.
// state | meaning: IDLE wait trigger | CONV wait both converter edges | ADAPT_RUN wait filter edge | CANCEL wait canceller edge | OUT load output, phase update
module echo_cancel_sequencer #(
    parameter int CNT_W          = 13,
    parameter int ITER_W         = 32,
    parameter int N_TAPS         = 16,
    parameter int WARM0_SAMPLES  = 16,
    parameter int WARM1_SAMPLES  = 16,
    parameter int ADAPT_SAMPLES  = 2000,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic              clk_operation,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  sampling_cycle_counter,
    input  logic              readapt,
    output logic              conv_start,
    input  logic              conv_ready_send,
    input  logic              conv_ready_lag,
    output logic              adapt_start,
    input  logic              adapt_ready,
    output logic              cancel_start,
    input  logic              cancel_ready,
    output logic              enable_sampling_adapt,
    output logic              enable_sampling_cancel,
    input  logic [63:0]       e_in,
    input  logic [63:0]       clean_in,
    output logic [63:0]       out_double,
    output logic              out_start,
    output logic [1:0]        phase,
    output logic [ITER_W-1:0] iteration,
    output logic [ITER_W-1:0] drop_cnt,
    output logic [ITER_W-1:0] overrun_cnt,
    output logic              timeout_err,
    output logic              busy
);

    // The filter delay line must be filled before its output is meaningful.
    localparam int WARM0_EFF = (WARM0_SAMPLES < N_TAPS) ? N_TAPS : WARM0_SAMPLES;
    localparam int WARM1_EFF = (WARM1_SAMPLES < N_TAPS) ? N_TAPS : WARM1_SAMPLES;
    localparam int WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_ADAPT_RUN, S_CANCEL, S_OUT} state_t;
    typedef enum logic [1:0] {PH_WARM0, PH_WARM1, PH_ADAPT, PH_TRACK} phase_t;

    state_t state, state_next;
    phase_t phase_q;

    logic prev_send, prev_lag, prev_adapt, prev_cancel;
    logic rise_send, rise_lag, rise_adapt, rise_cancel;
    logic got_send, got_lag;
    logic [WAIT_W-1:0] wait_cnt;
    logic wait_expired;
    logic sample_zero, trigger;
    logic conv_start_nxt, adapt_start_nxt, cancel_start_nxt, out_load, timeout_hit;
    logic readapt_pend;
    logic [ITER_W-1:0] phase_cnt, phase_cnt_inc;

    assign rise_send    = conv_ready_send & ~prev_send;
    assign rise_lag     = conv_ready_lag & ~prev_lag;
    assign rise_adapt   = adapt_ready & ~prev_adapt;
    assign rise_cancel  = cancel_ready & ~prev_cancel;
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign sample_zero  = (sampling_cycle_counter == '0);
    assign trigger      = enable && sample_zero;
    assign phase_cnt_inc = phase_cnt + ITER_W'(1);

    assign phase                  = phase_q;
    assign busy                   = (state != S_IDLE);
    assign enable_sampling_cancel = (phase_q != PH_WARM0);
    assign enable_sampling_adapt  = (phase_q == PH_ADAPT) || (phase_q == PH_TRACK);

    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        conv_start_nxt   = 1'b0;
        adapt_start_nxt  = 1'b0;
        cancel_start_nxt = 1'b0;
        out_load         = 1'b0;
        timeout_hit      = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_next     = S_CONV;
                    conv_start_nxt = 1'b1;
                end
            end
            S_CONV: begin
                if ((got_send || rise_send) && (got_lag || rise_lag)) begin
                    if (phase_q == PH_ADAPT) begin
                        state_next      = S_ADAPT_RUN;
                        adapt_start_nxt = 1'b1;
                    end else begin
                        state_next       = S_CANCEL;
                        cancel_start_nxt = 1'b1;
                    end
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            S_ADAPT_RUN: begin
                if (rise_adapt) begin
                    state_next       = S_CANCEL;
                    cancel_start_nxt = 1'b1;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            S_CANCEL: begin
                if (rise_cancel) begin
                    state_next = S_OUT;
                    out_load   = 1'b1;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            S_OUT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (timeout_hit) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            prev_send   <= 1'b0;
            prev_lag    <= 1'b0;
            prev_adapt  <= 1'b0;
            prev_cancel <= 1'b0;
            got_send    <= 1'b0;
            got_lag     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            prev_send   <= conv_ready_send;
            prev_lag    <= conv_ready_lag;
            prev_adapt  <= adapt_ready;
            prev_cancel <= cancel_ready;
            if (state != S_CONV) begin
                got_send <= 1'b0;
                got_lag  <= 1'b0;
            end else begin
                got_send <= got_send | rise_send;
                got_lag  <= got_lag | rise_lag;
            end
            if (state == S_IDLE || state_next != state) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            conv_start   <= 1'b0;
            adapt_start  <= 1'b0;
            cancel_start <= 1'b0;
            out_start    <= 1'b0;
            out_double   <= '0;
            timeout_err  <= 1'b0;
            drop_cnt     <= '0;
            overrun_cnt  <= '0;
        end else begin
            conv_start   <= conv_start_nxt;
            adapt_start  <= adapt_start_nxt;
            cancel_start <= cancel_start_nxt;
            out_start    <= out_load;
            if (out_load) begin
                out_double <= (phase_q != PH_TRACK) ? e_in : clean_in;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
                drop_cnt    <= drop_cnt + ITER_W'(1);
            end
            if (busy && sample_zero) begin
                overrun_cnt <= overrun_cnt + ITER_W'(1);
            end
        end
    end

    // Phase schedule advances only on completed samples; a pending readapt wins over ADAPT -> TRACK.
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            phase_q      <= PH_WARM0;
            phase_cnt    <= '0;
            iteration    <= '0;
            readapt_pend <= 1'b0;
        end else begin
            if (phase_q == PH_WARM0 || phase_q == PH_WARM1) begin
                readapt_pend <= 1'b0;
            end else if (state == S_OUT) begin
                readapt_pend <= readapt;
            end else if (readapt) begin
                readapt_pend <= 1'b1;
            end
            if (state == S_OUT) begin
                if (phase_q == PH_ADAPT) begin
                    iteration <= iteration + ITER_W'(1);
                end
                if (readapt_pend && (phase_q == PH_ADAPT || phase_q == PH_TRACK)) begin
                    phase_q   <= PH_ADAPT;
                    phase_cnt <= '0;
                end else begin
                    case (phase_q)
                        PH_WARM0: begin
                            if (phase_cnt_inc == ITER_W'(WARM0_EFF)) begin
                                phase_q   <= PH_WARM1;
                                phase_cnt <= '0;
                            end else begin
                                phase_cnt <= phase_cnt_inc;
                            end
                        end
                        PH_WARM1: begin
                            if (phase_cnt_inc == ITER_W'(WARM1_EFF)) begin
                                phase_q   <= PH_ADAPT;
                                phase_cnt <= '0;
                            end else begin
                                phase_cnt <= phase_cnt_inc;
                            end
                        end
                        PH_ADAPT: begin
                            if (ADAPT_SAMPLES != 0 && phase_cnt_inc == ITER_W'(ADAPT_SAMPLES)) begin
                                phase_q   <= PH_TRACK;
                                phase_cnt <= '0;
                            end else begin
                                phase_cnt <= phase_cnt_inc;
                            end
                        end
                        default: begin
                            phase_cnt <= phase_cnt;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_echo_cancel_sequencer.sv
// Scoreboard bench for echo_cancel_sequencer: randomized samples against a sample-level schedule model.
module tb_echo_cancel_sequencer;
    localparam int CNT_W = 13;
    localparam int ITER_W = 32;
    localparam int W0 = 16;
    localparam int W1 = 16;
    localparam int AS = 4;
    localparam int TO = 64;

    logic clk_operation = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic [CNT_W-1:0] sampling_cycle_counter = 13'd5;
    logic readapt = 1'b0;
    logic conv_start, adapt_start, cancel_start, out_start;
    logic conv_ready_send = 1'b0, conv_ready_lag = 1'b0, adapt_ready = 1'b0, cancel_ready = 1'b0;
    logic enable_sampling_adapt, enable_sampling_cancel;
    logic [63:0] e_in = '0, clean_in = '0, out_double;
    logic [1:0] phase;
    logic [ITER_W-1:0] iteration, drop_cnt, overrun_cnt;
    logic timeout_err, busy;

    echo_cancel_sequencer #(
        .CNT_W(CNT_W), .ITER_W(ITER_W), .N_TAPS(16), .WARM0_SAMPLES(W0),
        .WARM1_SAMPLES(W1), .ADAPT_SAMPLES(AS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_operation(clk_operation), .rst(rst), .enable(enable),
        .sampling_cycle_counter(sampling_cycle_counter), .readapt(readapt),
        .conv_start(conv_start), .conv_ready_send(conv_ready_send), .conv_ready_lag(conv_ready_lag),
        .adapt_start(adapt_start), .adapt_ready(adapt_ready),
        .cancel_start(cancel_start), .cancel_ready(cancel_ready),
        .enable_sampling_adapt(enable_sampling_adapt), .enable_sampling_cancel(enable_sampling_cancel),
        .e_in(e_in), .clean_in(clean_in), .out_double(out_double), .out_start(out_start),
        .phase(phase), .iteration(iteration), .drop_cnt(drop_cnt), .overrun_cnt(overrun_cnt),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk_operation = ~clk_operation;

    int cyc = 0;
    always @(posedge clk_operation) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] out;
        logic [1:0]  ph;
        logic [31:0] it;
    } exp_t;
    exp_t sbq[$];

    int m_phase = 0, m_cnt = 0, m_iter = 0, m_pend = 0;
    int accepted = 0, out_seen = 0;

    // A completed sample: output source, then schedule bookkeeping by sample counts.
    task automatic model_accept(logic [63:0] e, logic [63:0] c);
        exp_t x;
        x.out = (m_phase != 3) ? e : c;
        x.ph  = 2'(m_phase);
        x.it  = 32'(m_iter);
        sbq.push_back(x);
        accepted++;
        if (m_phase == 2) m_iter++;
        if (m_pend != 0 && m_phase >= 2) begin
            m_phase = 2;
            m_cnt = 0;
        end else if (m_phase != 3) begin
            m_cnt++;
            if ((m_phase == 0 && m_cnt == W0) || (m_phase == 1 && m_cnt == W1) ||
                (m_phase == 2 && m_cnt == AS)) begin
                m_phase++;
                m_cnt = 0;
            end
        end
        m_pend = 0;
    endtask

    int d_send = 1, d_lag = 1, d_adapt = 1, d_cancel = 1;
    int lag_raise_cyc = 0, adapt_start_cyc = 0, last_out_cyc = 0;

    initial forever begin
        @(negedge clk_operation);
        if (conv_start) begin
            conv_ready_send = 1'b0;
            if (d_send > 0) begin
                repeat (d_send) @(negedge clk_operation);
                conv_ready_send = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk_operation);
        if (conv_start) begin
            conv_ready_lag = 1'b0;
            if (d_lag > 0) begin
                repeat (d_lag) @(negedge clk_operation);
                conv_ready_lag = 1'b1;
                lag_raise_cyc = cyc;
            end
        end
    end

    initial forever begin
        @(negedge clk_operation);
        if (adapt_start) begin
            adapt_ready = 1'b0;
            if (d_adapt > 0) begin
                repeat (d_adapt) @(negedge clk_operation);
                adapt_ready = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk_operation);
        if (cancel_start) begin
            cancel_ready = 1'b0;
            if (d_cancel > 0) begin
                repeat (d_cancel) @(negedge clk_operation);
                cancel_ready = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk_operation);
        if (adapt_start) begin
            adapt_start_cyc = cyc;
            chk("adapt_start_phase", 64'(phase), 64'd2);
        end
        if (out_start) begin
            out_seen++;
            last_out_cyc = cyc;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_start: got out_double %0h expected no output", out_double);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("out_double", out_double, x.out);
                chk("out_phase", 64'(phase), 64'(x.ph));
                chk("out_iteration", 64'(iteration), 64'(x.it));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [CNT_W-1:0] nz();
        return CNT_W'($urandom_range(1, (1 << CNT_W) - 1));
    endfunction

    task automatic set_delays(int s, int l, int a, int c);
        d_send = s; d_lag = l; d_adapt = a; d_cancel = c;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk_operation);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s: got busy after %0d cycles expected idle", name, n);
        end
    endtask

    task automatic do_sample(bit chk_lat, bit pulse_readapt);
        logic [63:0] e = {$urandom(), $urandom()};
        logic [63:0] c = {$urandom(), $urandom()};
        int t, lat_exp;
        @(negedge clk_operation);
        e_in = e;
        clean_in = c;
        sampling_cycle_counter = '0;
        t = cyc;
        chk("en_cancel", 64'(enable_sampling_cancel), 64'(m_phase != 0));
        chk("en_adapt", 64'(enable_sampling_adapt), 64'(m_phase >= 2));
        lat_exp = (m_phase == 2) ? 7 : 5;
        if (pulse_readapt && m_phase >= 2) m_pend = 1;
        model_accept(e, c);
        @(negedge clk_operation);
        sampling_cycle_counter = nz();
        if (pulse_readapt) begin
            @(negedge clk_operation);
            readapt = 1'b1;
            @(negedge clk_operation);
            readapt = 1'b0;
        end
        wait_idle("sample_done");
        if (chk_lat) chk("latency", 64'(last_out_cyc - t), 64'(lat_exp));
    endtask

    task automatic rand_sample();
        if ($urandom_range(0, 1) == 1) begin
            set_delays(1, 1, 1, 1);
            do_sample(1, 0);
        end else begin
            set_delays($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
            do_sample(0, 0);
        end
    endtask

    initial begin
        int a, exp_ovr, per, busy_until, n;
        repeat (3) @(negedge clk_operation);
        chk("rst_phase", 64'(phase), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_iteration", 64'(iteration), 0);
        chk("rst_drop", 64'(drop_cnt), 0);
        chk("rst_overrun", 64'(overrun_cnt), 0);
        chk("rst_timeout", 64'(timeout_err), 0);
        chk("rst_out_double", out_double, 0);
        chk("rst_starts", 64'({conv_start, adapt_start, cancel_start, out_start}), 0);
        chk("rst_enables", 64'({enable_sampling_adapt, enable_sampling_cancel}), 0);
        rst = 1'b0;
        enable = 1'b1;
        sampling_cycle_counter = nz();
        repeat (2) @(negedge clk_operation);

        for (int i = 0; i < 36; i++) rand_sample();
        chk("phase_after_36", 64'(phase), 3);
        chk("iteration_after_36", 64'(iteration), 4);
        for (int i = 0; i < 4; i++) rand_sample();

        set_delays(1, 1, 1, 1);
        do_sample(1, 1);
        chk("phase_after_readapt", 64'(phase), 2);
        for (int i = 0; i < 4; i++) rand_sample();
        chk("phase_track_again", 64'(phase), 3);
        chk("iteration_continues", 64'(iteration), 8);

        set_delays(1, 1, 1, 1);
        do_sample(1, 1);
        set_delays(2, 12, 1, 1);
        do_sample(0, 0);
        chk("skew_adapt_after_lag", 64'(adapt_start_cyc - lag_raise_cyc), 1);

        // Adaptive filter never answers: sample must be dropped after TO cycles.
        set_delays(1, 1, 0, 1);
        @(negedge clk_operation);
        sampling_cycle_counter = '0;
        @(negedge clk_operation);
        sampling_cycle_counter = nz();
        n = 0;
        while (!adapt_start && n < 40) begin
            @(negedge clk_operation);
            n++;
        end
        chk("timeout_adapt_started", 64'(adapt_start), 1);
        a = cyc;
        repeat (TO - 1) @(negedge clk_operation);
        chk("timeout_not_early_busy", 64'(busy), 1);
        chk("timeout_not_early_drop", 64'(drop_cnt), 0);
        @(negedge clk_operation);
        chk("timeout_cycles", 64'(cyc - a), 64'(TO));
        chk("timeout_drop", 64'(drop_cnt), 1);
        chk("timeout_err", 64'(timeout_err), 1);
        chk("timeout_idle", 64'(busy), 0);
        chk("timeout_iteration", 64'(iteration), 64'(m_iter));
        set_delays(1, 1, 1, 1);
        do_sample(1, 0);
        do_sample(0, 0);
        do_sample(0, 0);
        chk("phase_track_before_overrun", 64'(phase), 3);

        // Zero crossings faster than the 5-cycle TRACK latency.
        per = $urandom_range(2, 4);
        exp_ovr = 0;
        busy_until = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_operation);
            if (c % per == 0) begin
                sampling_cycle_counter = '0;
                if (c > busy_until) begin
                    busy_until = c + 5;
                    e_in = {$urandom(), $urandom()};
                    clean_in = {$urandom(), $urandom()};
                    model_accept(e_in, clean_in);
                end else begin
                    exp_ovr++;
                end
            end else begin
                sampling_cycle_counter = nz();
            end
        end
        @(negedge clk_operation);
        sampling_cycle_counter = nz();
        wait_idle("overrun_done");
        chk("overrun_cnt", 64'(overrun_cnt), 64'(exp_ovr));

        enable = 1'b0;
        @(negedge clk_operation);
        sampling_cycle_counter = '0;
        @(negedge clk_operation);
        sampling_cycle_counter = nz();
        @(negedge clk_operation);
        chk("enable_blocks", 64'(busy), 0);
        chk("enable_no_overrun", 64'(overrun_cnt), 64'(exp_ovr));
        enable = 1'b1;
        chk("out_count", 64'(out_seen), 64'(accepted));

        // Asynchronous reset while waiting on the canceller.
        set_delays(1, 1, 1, 20);
        @(negedge clk_operation);
        sampling_cycle_counter = '0;
        @(negedge clk_operation);
        sampling_cycle_counter = nz();
        n = 0;
        while (!cancel_start && n < 40) begin
            @(negedge clk_operation);
            n++;
        end
        chk("cancel_started", 64'(cancel_start), 1);
        repeat (3) @(negedge clk_operation);
        #2 rst = 1'b1;
        #1;
        chk("arst_phase", 64'(phase), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_counters", 64'(iteration | drop_cnt | overrun_cnt), 0);
        chk("arst_timeout", 64'(timeout_err), 0);
        chk("arst_out_double", out_double, 0);
        chk("arst_enables", 64'({enable_sampling_adapt, enable_sampling_cancel}), 0);
        chk("arst_starts", 64'({conv_start, adapt_start, cancel_start, out_start}), 0);
        @(negedge clk_operation);
        rst = 1'b0;
        repeat (30) @(negedge clk_operation);
        chk("arst_needs_trigger", 64'(busy), 0);
        m_phase = 0; m_cnt = 0; m_iter = 0; m_pend = 0;
        set_delays(1, 1, 1, 1);
        do_sample(1, 0);
        chk("out_count_final", 64'(out_seen), 64'(accepted));
        chk("scoreboard_empty", 64'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/echo_cancel_sequencer.md
Name: echo_cancel_sequencer

Overview:
- Synthesizable, handshake-driven control sequencer for the echo-cancellation datapath.
- Replaces fixed-delay stepping of the double converters, adaptive filter, canceller and output converter with per-stage start/ready handshakes and a parametrised phase schedule (warm-up, adapt, track, re-adapt).
- Adds per-stage timeouts, overrun detection and a selectable output source.
- Sits between the sampling-cycle counter and the MUT-style sub-blocks in the echo-cancellation top level.

Parameters:
- CNT_W, 13, width of sampling_cycle_counter.
- ITER_W, 32, width of the iteration and diagnostic counters.
- N_TAPS, 16, filter length; WARM0_SAMPLES and WARM1_SAMPLES must each be at least N_TAPS.
- WARM0_SAMPLES, 16, samples with both sampling enables low.
- WARM1_SAMPLES, 16, samples with only canceller sampling enabled.
- ADAPT_SAMPLES, 2000, adaptation samples before freezing; 0 means adapt forever.
- TIMEOUT_CYCLES, 2048, maximum wait per stage handshake.

Ports:
- clk_operation  in  1  operation clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  permits new samples to start.
- sampling_cycle_counter  in  CNT_W  a sample starts when this equals 0.
- readapt  in  1  one-cycle request to return to ADAPT.
- conv_start  out  1  one-cycle start pulse to both sig16b_to_double converters.
- conv_ready_send  in  1  send-path converter ready (level).
- conv_ready_lag  in  1  lag-path converter ready (level).
- adapt_start  out  1  one-cycle start pulse to the adaptive filter.
- adapt_ready  in  1  adaptive filter ready (level).
- cancel_start  out  1  one-cycle start pulse to the canceller.
- cancel_ready  in  1  canceller ready (level).
- enable_sampling_adapt  out  1  sampling enable to the adaptive filter.
- enable_sampling_cancel  out  1  sampling enable to the canceller.
- e_in  in  64  adaptive-filter error (double).
- clean_in  in  64  canceller output (double).
- out_double  out  64  value to double_to_sig16b.
- out_start  out  1  one-cycle pulse that loads the output converter.
- phase  out  2  0=WARM0, 1=WARM1, 2=ADAPT, 3=TRACK.
- iteration  out  ITER_W  completed adaptation samples.
- drop_cnt  out  ITER_W  samples aborted by timeout.
- overrun_cnt  out  ITER_W  sample triggers that arrived while busy.
- timeout_err  out  1  sticky timeout flag.
- busy  out  1  high when the sample FSM is not in IDLE.

Behaviour:
- Reset (async, any state): all outputs 0; phase=WARM0; sample FSM=IDLE; phase sample counter=0; rising-edge history registers=0.
- Sample FSM states: IDLE, CONV, ADAPT_RUN, CANCEL, OUT.
- IDLE -> CONV: when enable=1 and sampling_cycle_counter==0. conv_start pulses on the transition cycle.
- Ready detection:
  - A stage completes on the first rising edge of its ready (registered previous value 0, current 1) seen after its start pulse.
  - CONV completes only once both converter edges have been captured; the two edges may arrive in any order or in the same cycle.
  - A ready already high at start does not count.
- CONV done:
  - If phase=ADAPT, go to ADAPT_RUN and pulse adapt_start.
  - Otherwise go to CANCEL and pulse cancel_start; adaptation is skipped in WARM0, WARM1 and TRACK.
- ADAPT_RUN done: go to CANCEL and pulse cancel_start.
- CANCEL done: go to OUT.
- OUT (one cycle):
  - out_double <= e_in when phase != TRACK, else clean_in. Registered; held until the next OUT.
  - out_start pulses.
  - iteration increments if phase=ADAPT.
  - Phase bookkeeping is applied (see below); FSM returns to IDLE.
- Minimum latency from trigger to out_start, with each ready edge arriving in the cycle after its start pulse: ADAPT phase = 7 cycles; other phases = 5 cycles.
- Timeout:
  - A per-stage wait counter resets on every state entry.
  - Reaching TIMEOUT_CYCLES in CONV, ADAPT_RUN or CANCEL causes: timeout_err <= 1 (sticky), drop_cnt + 1, FSM to IDLE with no out_start.
  - Phase counter and iteration are unchanged on a timeout.
- Overrun: sampling_cycle_counter==0 while busy=1 and not in the trigger cycle increments overrun_cnt. The in-flight sample continues and the trigger is discarded.
- Enable: enable=0 blocks new triggers only. An in-flight sample runs to completion or timeout.
- Phase schedule:
  - The phase counter advances in OUT only.
  - WARM0 -> WARM1 after WARM0_SAMPLES completed samples; WARM1 -> ADAPT after WARM1_SAMPLES.
  - ADAPT -> TRACK after ADAPT_SAMPLES when that parameter is nonzero; TRACK is terminal until readapt.
  - The phase counter clears on every phase change.
- Sampling enables are combinational decodes of phase:
  - enable_sampling_cancel = (phase != WARM0).
  - enable_sampling_adapt = (phase is ADAPT or TRACK).
- readapt:
  - Latched into a pending bit.
  - Applied in the next OUT: phase <= ADAPT and the phase counter clears; iteration is not cleared.
  - If applied while already in ADAPT, it only restarts the ADAPT count.
  - readapt during WARM0 or WARM1 is ignored and the pending bit is cleared.
- Simultaneous events:
  - A readapt pending in the same OUT as the ADAPT -> TRACK transition wins: phase stays ADAPT.
  - An IDLE trigger coinciding with OUT cannot occur, because OUT always returns to IDLE first. A trigger seen during OUT counts as an overrun.
- Counters wrap at 2^ITER_W without saturation.

Test Plan:
- Nominal schedule: WARM0=WARM1=16, ADAPT=4, all readys edge 1 cycle after start.
  - Phase goes 0 for 16 samples, 1 for 16, 2 for 4, then 3.
  - iteration=4 after 36 samples.
  - adapt_start is never seen outside phase 2.
  - out_double equals e_in through sample 36 and clean_in from sample 37.
- Ready skew: conv_ready_lag rises 10 cycles after conv_ready_send.
  - adapt_start pulses exactly 1 cycle after the later edge.
  - A ready held high from the prior sample does not advance CONV.
- Timeout: adapt_ready held low, TIMEOUT_CYCLES=64.
  - timeout_err=1 and drop_cnt=1 at 64 cycles into ADAPT_RUN; no out_start; iteration unchanged.
  - The next trigger starts normally.
- Overrun: sampling_cycle_counter period shorter than the stage latency.
  - overrun_cnt increments once per extra zero crossing while busy.
  - out_start count equals the number of accepted samples.
- readapt in TRACK, pulsed mid-sample: phase returns to 2 at that sample's OUT, then TRACK again after 4 more samples; iteration continues from its prior value.
- Reset mid-CANCEL (rst asserted asynchronously between clock edges): all outputs 0 and phase=0 immediately, without waiting for a clock edge; after release, a fresh trigger is needed to restart.
